// File: rtl/alarm_pkg.sv
// Shared encodings and time-word layout for the alarm scheduler slice.
package alarm_pkg;

  // FSM state encodings, also presented on alarm_state for the LCD mode logic
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RINGING = 3'd2,
    ST_SNOOZE  = 3'd3,
    ST_DISMISS = 3'd4
  } alarm_state_e;

  // Packed binary time word: {year[11:0], month, day, hour, minute, second}
  localparam int TIME_W  = 52;
  localparam int YEAR_HI = 51;
  localparam int YEAR_LO = 40;
  localparam int MON_HI  = 39;
  localparam int MON_LO  = 32;
  localparam int DAY_HI  = 31;
  localparam int DAY_LO  = 24;
  localparam int HOUR_HI = 23;
  localparam int HOUR_LO = 16;
  localparam int MIN_HI  = 15;
  localparam int MIN_LO  = 8;
  localparam int SEC_HI  = 7;
  localparam int SEC_LO  = 0;

  // Width of the ring/snooze countdown and the snooze budget counter
  localparam int TMR_W = 16;
  localparam int SNZ_W = 4;

endpackage

// File: rtl/sec_countdown.sv
// Loadable 16-bit seconds down-counter that saturates at zero.
module sec_countdown
  import alarm_pkg::*;
(
  input  logic             clk1sec,
  input  logic             rst,
  input  logic             load,
  input  logic [TMR_W-1:0] load_val,
  input  logic             en,
  output logic [TMR_W-1:0] count,
  output logic             zero
);

  // Load has priority over counting; decrement stops at zero instead of wrapping
  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/alarm_scheduler.sv
// Alarm sequencer: arms on a stored alarm, rings on an exact time match, and
// runs the ring / snooze / dismiss cycle with a bounded snooze budget.
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int RING_SEC   = 60,
  parameter int SNOOZE_SEC = 300,
  parameter int MAX_SNOOZE = 3
) (
  input  logic              clk1sec,
  input  logic              rst,
  input  logic              alarm_en,
  input  logic [TIME_W-1:0] bin_alarm,
  input  logic [TIME_W-1:0] bin_now,
  input  logic              btn_stop,
  input  logic              btn_snooze,
  output logic              ring,
  output logic              beep,
  output logic              rst_alarm,
  output logic [2:0]        alarm_state,
  output logic [SNZ_W-1:0]  snooze_left,
  output logic [TMR_W-1:0]  remain_sec
);

  localparam logic [TMR_W-1:0] RING_LD   = TMR_W'(RING_SEC - 1);
  localparam logic [TMR_W-1:0] SNOOZE_LD = TMR_W'(SNOOZE_SEC - 1);
  localparam logic [SNZ_W-1:0] SNZ_MAX   = SNZ_W'(MAX_SNOOZE);

  alarm_state_e     state, state_nxt;
  logic             armed_ok, match;
  logic             tmr_load, tmr_en, tmr_zero;
  logic [TMR_W-1:0] tmr_val, tmr_count;
  logic             tone, tone_set, tone_tog;
  logic             sl_dec, sl_reload;

  assign armed_ok = alarm_en && (bin_alarm != '0);
  assign match    = (bin_now == bin_alarm);

  sec_countdown u_timer (
    .clk1sec  (clk1sec),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .en       (tmr_en),
    .count    (tmr_count),
    .zero     (tmr_zero)
  );

  // State register
  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode plus timer, tone and snooze-budget controls
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_en    = 1'b0;
    tone_set  = 1'b0;
    tone_tog  = 1'b0;
    sl_dec    = 1'b0;
    sl_reload = 1'b0;
    if (!alarm_en && (state != ST_DISMISS)) begin
      // Switching the alarm off abandons the event silently; the stored alarm stays
      state_nxt = ST_IDLE;
      sl_reload = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (armed_ok) state_nxt = ST_ARMED;
        end
        ST_ARMED: begin
          if (!armed_ok) begin
            state_nxt = ST_IDLE;
          end else if (match) begin
            state_nxt = ST_RINGING;
            tmr_load  = 1'b1;
            tmr_val   = RING_LD;
            tone_set  = 1'b1;
          end
        end
        ST_RINGING: begin
          // Stop beats snooze beats timeout; a snooze with no budget left is ignored
          if (btn_stop) begin
            state_nxt = ST_DISMISS;
          end else if ((btn_snooze || tmr_zero) && (snooze_left != '0)) begin
            state_nxt = ST_SNOOZE;
            tmr_load  = 1'b1;
            tmr_val   = SNOOZE_LD;
            sl_dec    = 1'b1;
          end else if (tmr_zero) begin
            state_nxt = ST_DISMISS;
          end else begin
            tmr_en   = 1'b1;
            tone_tog = 1'b1;
          end
        end
        ST_SNOOZE: begin
          if (btn_stop) begin
            state_nxt = ST_DISMISS;
          end else if (tmr_zero) begin
            state_nxt = ST_RINGING;
            tmr_load  = 1'b1;
            tmr_val   = RING_LD;
            tone_set  = 1'b1;
          end else begin
            tmr_en = 1'b1;
          end
        end
        ST_DISMISS: begin
          state_nxt = ST_IDLE;
          sl_reload = 1'b1;
        end
        default: begin
          state_nxt = ST_IDLE;
        end
      endcase
    end
  end

  // Tone phase: restarts on at every ring burst, flips each second while ringing
  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      tone <= 1'b0;
    end else if (tone_set) begin
      tone <= 1'b1;
    end else if (tone_tog) begin
      tone <= ~tone;
    end
  end

  // Snooze budget for the current alarm event
  always_ff @(posedge clk1sec or negedge rst) begin
    if (!rst) begin
      snooze_left <= SNZ_MAX;
    end else if (sl_reload) begin
      snooze_left <= SNZ_MAX;
    end else if (sl_dec) begin
      snooze_left <= snooze_left - 1'b1;
    end
  end

  assign alarm_state = state;
  assign ring        = (state == ST_RINGING);
  assign beep        = ring && tone;
  assign rst_alarm   = (state == ST_DISMISS);
  assign remain_sec  = ((state == ST_RINGING) || (state == ST_SNOOZE)) ? tmr_count : '0;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Scoreboard bench for alarm_scheduler with RING_SEC=5, SNOOZE_SEC=10, MAX_SNOOZE=2.
module tb_alarm_scheduler;
  import alarm_pkg::*;

  logic              clk1sec = 1'b0;
  logic              rst = 1'b1;
  logic              alarm_en = 1'b0;
  logic [TIME_W-1:0] bin_alarm = '0;
  logic [TIME_W-1:0] bin_now = '0;
  logic              btn_stop = 1'b0;
  logic              btn_snooze = 1'b0;
  logic              ring, beep, rst_alarm;
  logic [2:0]        alarm_state;
  logic [3:0]        snooze_left;
  logic [15:0]       remain_sec;

  int n_tests = 0;
  int n_fail  = 0;

  string       nm_q[$];
  logic [25:0] v_q[$];

  alarm_scheduler #(.RING_SEC(5), .SNOOZE_SEC(10), .MAX_SNOOZE(2)) dut (
    .clk1sec     (clk1sec),
    .rst         (rst),
    .alarm_en    (alarm_en),
    .bin_alarm   (bin_alarm),
    .bin_now     (bin_now),
    .btn_stop    (btn_stop),
    .btn_snooze  (btn_snooze),
    .ring        (ring),
    .beep        (beep),
    .rst_alarm   (rst_alarm),
    .alarm_state (alarm_state),
    .snooze_left (snooze_left),
    .remain_sec  (remain_sec)
  );

  always #5 clk1sec = ~clk1sec;

  // Expected observation: state, snooze_left, remain_sec, ring, beep, rst_alarm
  task automatic push(input string nm, input logic [2:0] st, input int sl, input int rem,
                      input bit rng, input bit bp, input bit clr);
    nm_q.push_back(nm);
    v_q.push_back({st, 4'(sl), 16'(rem), rng, bp, clr});
  endtask

  task automatic check_one();
    string       nm;
    logic [25:0] e, a;
    nm = nm_q.pop_front();
    e  = v_q.pop_front();
    a  = {alarm_state, snooze_left, remain_sec, ring, beep, rst_alarm};
    n_tests++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got st=%0d sl=%0d rem=%0d ring=%0b beep=%0b rst_alarm=%0b, expected st=%0d sl=%0d rem=%0d ring=%0b beep=%0b rst_alarm=%0b",
               nm, a[25:23], a[22:19], a[18:3], a[2], a[1], a[0],
               e[25:23], e[22:19], e[18:3], e[2], e[1], e[0]);
    end
  endtask

  // Monitor: outputs settle after each clock edge and after an async reset assertion
  always @(posedge clk1sec) begin
    #1;
    if (nm_q.size() > 0) check_one();
  end

  always @(negedge rst) begin
    #1;
    if (nm_q.size() > 0) check_one();
  end

  // One clock cycle: expectation for the state after the coming edge, then advance time
  task automatic tick(input string nm, input logic [2:0] st, input int sl, input int rem,
                      input bit rng, input bit bp, input bit clr);
    push(nm, st, sl, rem, rng, bp, clr);
    @(negedge clk1sec);
    bin_now = bin_now + 1;
  endtask

  // Store an alarm 3 s ahead and walk through the armed wait
  task automatic arm(input int sl);
    bin_alarm = bin_now + 3;
    for (int i = 0; i < 3; i++) tick("armed_wait", ST_ARMED, sl, 0, 0, 0, 0);
  endtask

  // Five-second ring burst: remain 4..0, beep 1,0,1,0,1
  task automatic ring_phase(input string nm, input int sl);
    for (int i = 0; i < 5; i++) tick(nm, ST_RINGING, sl, 4 - i, 1, (i % 2) == 0, 0);
  endtask

  // Ten-second snooze: remain 9..0, silent
  task automatic snooze_phase(input string nm, input int sl);
    for (int i = 0; i < 10; i++) tick(nm, ST_SNOOZE, sl, 9 - i, 0, 0, 0);
  endtask

  initial begin
    bin_now = 52'h7E8_0A_0F_08_1E_00;
    push("reset_state", ST_IDLE, 2, 0, 0, 0, 0);
    #2 rst = 1'b0;
    @(negedge clk1sec);
    rst      = 1'b1;
    alarm_en = 1'b1;

    // First ring, then full unattended sequence ending in auto-dismiss
    arm(2);
    ring_phase("ring1", 2);
    snooze_phase("auto_snooze1", 1);
    ring_phase("ring2", 1);
    snooze_phase("auto_snooze2", 0);
    btn_snooze = 1'b1;
    ring_phase("ring3_snooze_ignored", 0);
    tick("timeout_dismiss", ST_DISMISS, 0, 0, 0, 0, 1);
    btn_snooze = 1'b0;
    bin_alarm  = '0;
    tick("after_dismiss", ST_IDLE, 2, 0, 0, 0, 0);
    tick("unset_stays_idle", ST_IDLE, 2, 0, 0, 0, 0);

    // Manual snooze on the second ring second, snooze button ignored while snoozing
    arm(2);
    tick("ring_start", ST_RINGING, 2, 4, 1, 1, 0);
    tick("ring_2nd", ST_RINGING, 2, 3, 1, 0, 0);
    btn_snooze = 1'b1;
    tick("manual_snooze", ST_SNOOZE, 1, 9, 0, 0, 0);
    for (int i = 1; i < 10; i++) begin
      btn_snooze = (i == 3) || (i == 4);
      tick("snooze_count", ST_SNOOZE, 1, 9 - i, 0, 0, 0);
    end
    btn_snooze = 1'b0;
    tick("resume_ring", ST_RINGING, 1, 4, 1, 1, 0);

    // Stop and snooze together: stop wins, budget shown unreloaded during DISMISS
    btn_stop   = 1'b1;
    btn_snooze = 1'b1;
    tick("stop_beats_snooze", ST_DISMISS, 1, 0, 0, 0, 1);
    btn_stop   = 1'b0;
    btn_snooze = 1'b0;
    bin_alarm  = '0;
    tick("stop_reload", ST_IDLE, 2, 0, 0, 0, 0);

    // alarm_en dropped mid-snooze after the stored alarm was edited
    arm(2);
    ring_phase("ring_t5", 2);
    tick("snooze_t5", ST_SNOOZE, 1, 9, 0, 0, 0);
    bin_alarm = bin_alarm + 1000;
    tick("alarm_edit_kept", ST_SNOOZE, 1, 8, 0, 0, 0);
    tick("alarm_edit_kept", ST_SNOOZE, 1, 7, 0, 0, 0);
    alarm_en = 1'b0;
    tick("disable_to_idle", ST_IDLE, 2, 0, 0, 0, 0);
    alarm_en = 1'b1;
    tick("reenable_armed", ST_ARMED, 2, 0, 0, 0, 0);

    // Asynchronous reset while ringing
    arm(2);
    tick("ring_t6", ST_RINGING, 2, 4, 1, 1, 0);
    tick("ring_t6", ST_RINGING, 2, 3, 1, 0, 0);
    push("async_reset", ST_IDLE, 2, 0, 0, 0, 0);
    #2 rst = 1'b0;
    @(negedge clk1sec);
    rst       = 1'b1;
    bin_alarm = '0;
    for (int i = 0; i < 3; i++) tick("zero_alarm_idle", ST_IDLE, 2, 0, 0, 0, 0);

    #20;
    n_tests++;
    if (nm_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", nm_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
